// File: rtl/salu_branch_resolve_pkg.sv
// Shared definitions for SALU branch resolution: widths, branch opcodes and
// the branch condition evaluator.
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif

package salu_branch_resolve_pkg;
   localparam int WF_ID_LENGTH = `WF_ID_LENGTH;
   localparam int WF_PER_CU    = `WF_PER_CU;
   localparam int PC_WIDTH     = 32;

   typedef enum logic [2:0] {
      BR_ALWAYS = 3'd0,
      BR_SCC0   = 3'd1,
      BR_SCC1   = 3'd2,
      BR_VCCZ   = 3'd3,
      BR_VCCNZ  = 3'd4,
      BR_EXECZ  = 3'd5,
      BR_EXECNZ = 3'd6,
      BR_RSVD   = 3'd7
   } br_op_e;

   typedef struct packed {
      logic [WF_ID_LENGTH-1:0] wfid;
      logic                    taken;
      logic [PC_WIDTH-1:0]     tgt_pc;
      logic [PC_WIDTH-1:0]     seq_pc;
   } br_stage1_t;

   typedef struct packed {
      logic [WF_ID_LENGTH-1:0] wfid;
      logic                    taken;
      logic [PC_WIDTH-1:0]     pc;
   } br_stage2_t;

   // The reserved opcode resolves as not taken.
   function automatic logic br_cond(input logic [2:0] op, input logic scc,
                                    input logic vccz, input logic execz);
      case (op)
         BR_ALWAYS: br_cond = 1'b1;
         BR_SCC0:   br_cond = ~scc;
         BR_SCC1:   br_cond = scc;
         BR_VCCZ:   br_cond = vccz;
         BR_VCCNZ:  br_cond = ~vccz;
         BR_EXECZ:  br_cond = execz;
         BR_EXECNZ: br_cond = ~execz;
         default:   br_cond = 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/decoder_6b_40b_en.sv
// One-hot decoder from a 6-bit wavefront id to a 40-bit mask, gated by en.
module decoder_6b_40b_en (
   input  logic [5:0]  addr_in,
   input  logic        en,
   output logic [39:0] out
);
   always_comb begin
      out = '0;
      for (int i = 0; i < 40; i++) begin
         out[i] = en && (addr_in == 6'(i));
      end
   end
endmodule

// File: rtl/dff.sv
// Generic register cell with synchronous active-high reset to zero.
module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= d;
   end
endmodule

// File: rtl/salu_branch_resolve.sv
// Two-stage SALU branch resolver: evaluates the condition, picks the next PC
// and pulses the result to fetch/issue while tracking in-flight wavefronts.
module salu_branch_resolve
   import salu_branch_resolve_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_branch_valid,
   input  logic [WF_ID_LENGTH-1:0] issue_wfid,
   input  logic [2:0]              issue_br_op,
   input  logic [PC_WIDTH-1:0]     issue_pc,
   input  logic [15:0]             issue_simm16,
   input  logic                    issue_scc,
   input  logic                    issue_vccz,
   input  logic                    issue_execz,
   output logic                    f_salu_branch_en,
   output logic [WF_ID_LENGTH-1:0] f_salu_branch_wfid,
   output logic                    f_salu_branch_taken,
   output logic [PC_WIDTH-1:0]     f_salu_branch_pc,
   output logic [WF_PER_CU-1:0]    inflight_arry,
   output logic                    err_double_branch
);
   logic                       accept;
   logic signed [PC_WIDTH-1:0] offset;
   logic                       vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
   br_stage1_t                 br_p1_d, br_p1_q;
   br_stage2_t                 br_p2_d, br_p2_q;
   logic [WF_PER_CU-1:0]       set_mask, clr_mask;
   logic [WF_PER_CU-1:0]       inflight_d, inflight_q;
   logic                       err_d, err_q;

   assign accept = issue_branch_valid && !rst;

   // Stage 1: condition result and both candidate PCs
   always_comb begin
      offset         = {{(PC_WIDTH-18){issue_simm16[15]}}, issue_simm16, 2'b00};
      vld_p1_d       = accept;
      br_p1_d.wfid   = issue_wfid;
      br_p1_d.taken  = br_cond(issue_br_op, issue_scc, issue_vccz, issue_execz);
      br_p1_d.seq_pc = issue_pc + PC_WIDTH'(4);
      br_p1_d.tgt_pc = issue_pc + PC_WIDTH'(4) + $unsigned(offset);
   end

   dff #(.W(1))                  u_vld_p1 (.clk(clk), .rst(rst), .d(vld_p1_d), .q(vld_p1_q));
   dff #(.W($bits(br_stage1_t))) u_br_p1  (.clk(clk), .rst(rst), .d(br_p1_d),  .q(br_p1_q));

   // Stage 2: selected next PC and the resolution pulse
   always_comb begin
      vld_p2_d      = vld_p1_q;
      br_p2_d.wfid  = br_p1_q.wfid;
      br_p2_d.taken = br_p1_q.taken;
      br_p2_d.pc    = br_p1_q.taken ? br_p1_q.tgt_pc : br_p1_q.seq_pc;
   end

   dff #(.W(1))                  u_vld_p2 (.clk(clk), .rst(rst), .d(vld_p2_d), .q(vld_p2_q));
   dff #(.W($bits(br_stage2_t))) u_br_p2  (.clk(clk), .rst(rst), .d(br_p2_d),  .q(br_p2_q));

   decoder_6b_40b_en u_set_dec (.addr_in(issue_wfid),   .en(accept),   .out(set_mask));
   decoder_6b_40b_en u_clr_dec (.addr_in(br_p2_q.wfid), .en(vld_p2_q), .out(clr_mask));

   // A new accept beats the clear of an older branch for the same wavefront.
   always_comb begin
      inflight_d = (inflight_q & ~clr_mask) | set_mask;
      err_d      = err_q;
      if (accept && ((|(set_mask & inflight_q & ~clr_mask)) || (issue_br_op == BR_RSVD))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign f_salu_branch_en    = vld_p2_q;
   assign f_salu_branch_wfid  = br_p2_q.wfid;
   assign f_salu_branch_taken = br_p2_q.taken;
   assign f_salu_branch_pc    = br_p2_q.pc;
   assign inflight_arry       = inflight_q;
   assign err_double_branch   = err_q;
endmodule

// File: doc/salu_branch_resolve.md
# salu_branch_resolve

Producer side of the pending-branch protocol: evaluates branch instructions issued to the SALU, computes the taken/not-taken outcome and target PC, and reports resolution to fetch and issue on f_salu_branch_*. Issue marks a wavefront pending when it issues the branch; this block's f_salu_branch_en/f_salu_branch_wfid pulse is the only event that clears that mark. The block sits in the SALU path between issue and fetch.

## Interface
- WF_ID_LENGTH, 6: wavefront id width (`WF_ID_LENGTH).
- WF_PER_CU, 40: wavefronts per CU (`WF_PER_CU).
- PC_WIDTH, 32: program counter width.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- issue_branch_valid  in  1  branch op issued to SALU this cycle.
- issue_wfid  in  WF_ID_LENGTH  issuing wavefront.
- issue_br_op  in  3  branch opcode; encodings in the shared package.
- issue_pc  in  PC_WIDTH  PC of the branch instruction.
- issue_simm16  in  16  signed word offset.
- issue_scc  in  1  SCC of the wavefront.
- issue_vccz  in  1  VCC is all-zero.
- issue_execz  in  1  EXEC is all-zero.
- f_salu_branch_en  out  1  one-cycle resolution pulse.
- f_salu_branch_wfid  out  WF_ID_LENGTH  resolved wavefront.
- f_salu_branch_taken  out  1  outcome.
- f_salu_branch_pc  out  PC_WIDTH  next PC for the wavefront.
- inflight_arry  out  WF_PER_CU  bit per wavefront with a branch accepted but not yet resolved.
- err_double_branch  out  1  sticky error flag.

## Operation
- Opcodes:
  - BR_ALWAYS: taken.
  - BR_SCC0: taken if !scc. BR_SCC1: taken if scc.
  - BR_VCCZ: taken if vccz. BR_VCCNZ: taken if !vccz.
  - BR_EXECZ: taken if execz. BR_EXECNZ: taken if !execz.
  - Code 7 is reserved: treated as not taken and sets err_double_branch.
- Target = issue_pc + 4 + (sign_extend(simm16) << 2), modulo 2^PC_WIDTH (wraps silently).
- f_salu_branch_pc = target if taken, else issue_pc + 4.
- Stage 1 registers the op fields, the condition result and both candidate PCs. Stage 2 registers the selected PC, taken, wfid and en.
- Throughput: one branch per cycle; no backpressure.
- inflight_arry:
  - Bit set on accept (decoded issue_wfid).
  - Bit cleared when the stage-2 pulse for that wfid is output.
  - Set and clear for the same wfid in the same cycle: the set wins (new branch still pending).
- err_double_branch sets when a branch is accepted for a wfid whose inflight bit is already set and not clearing this cycle. The branch is still processed. The flag stays set until rst.
- Reset values: all outputs 0; pipeline valids 0; inflight_arry 0.

## Timing
- Issue in cycle N produces f_salu_branch_en high in cycle N+2 for exactly one cycle, with wfid, taken and pc valid in that same cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back issues in N and N+1 produce pulses in N+2 and N+3, in order.
- rst asserted in any cycle: both stages and inflight_arry clear on the next edge. Branches in flight are dropped with no pulse. The issue side clears its pending marks on the same reset.
- issue_branch_valid while rst is high is ignored.

## Structure
- Shared package/defines holds:
  - BR_* 3-bit opcode encodings.
  - PC_WIDTH.
  - Existing `WF_ID_LENGTH and `WF_PER_CU.
- Reuse decoder_6b_40b_en for the set and clear masks of inflight_arry.
- Condition evaluation and PC arithmetic stay inline; no further sub-modules.
- Pipeline registers use the standard dff cell with synchronous rst.

## Test plan
- BR_ALWAYS: wfid 5, pc 0x100, simm16 0x0010, issued cycle 10. Cycle 12: en=1, wfid=5, taken=1, pc=0x144. inflight bit 5 is high in cycles 11-12 and low in cycle 13.
- BR_SCC1 with scc=0: pc 0x200, simm16 0xFFFF. Not taken, pc=0x204. Same op with scc=1: taken, pc=0x200.
- Wrap-around: pc 0xFFFFFFFC, simm16 0x0001, BR_EXECNZ with execz=0. Taken, pc=0x00000004.
- Back-to-back: wfids 1, 2, 39 issued on consecutive cycles. Three consecutive pulses in the same order, each with correct fields.
- Double branch: wfid 7 issued twice one cycle apart. err_double_branch=1 from the second accept onward; two pulses are still produced.
- Same-cycle set/clear: wfid 7 issued in the cycle its earlier branch pulses. Bit 7 stays high and err_double_branch stays 0.
- Reset: rst asserted in cycle N+1 after an issue in cycle N. No pulse in N+2; inflight_arry is 0 from N+2.
